// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display controller.
// Segment patterns here are active-high with bit0..6 = A..G; polarity is applied at the pins.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Elaboration-time helper for the decimal overflow threshold.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, WIDTH shifts, then a one-cycle COMMIT.
// With hex_i set the add-3 adjust is bypassed, so the register ends up holding the raw nibbles.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  hex_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  conv_state_e state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                hex_q, hex_d;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    logic [3:0] nib;
    assign nib = bcd_q[4*gi +: 4];
    assign adj[4*gi +: 4] = (!hex_q && nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SHIFT;
          bin_d   = data_i;
          bcd_d   = '0;
          cnt_d   = '0;
          hex_d   = hex_i;
        end
      end
      SHIFT: begin
        bcd_d = (adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == COMMIT);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// N-digit multiplexed 7-segment driver: captures a value on load, converts it to hex or BCD
// digits, then scans them out with leading-zero blanking, radix points and an overflow dash.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int WIDTH      = 16,
  parameter int SCAN_DIV   = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data,
  input  logic              load,
  input  logic              dec_mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNTW = $clog2(SCAN_DIV);
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);

  logic                accept, conv_done;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [63:0]         data_ext;
  logic                ovf_in;
  logic                ovf_pend_q, ovf_pend_d, ovf_q, ovf_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [CNTW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [DIGITS-1:0]   sel_q, sel_d, onehot;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0][7:0] seg_hi;
  logic [DIGITS-1:0]   upper_zero;

  assign accept   = load && !busy;
  assign data_ext = 64'(data);
  assign ovf_in   = dec_mode ? (data_ext >= DEC_LIMIT)
                             : ((data_ext >> (4*DIGITS)) != 64'd0);

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .hex_i   (!dec_mode),
    .data_i  (data),
    .busy_o  (busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Overflow is judged at capture time but only becomes visible together with the digits.
  always_comb begin
    ovf_pend_d = accept ? ovf_in : ovf_pend_q;
    disp_d     = conv_done ? conv_bcd : disp_q;
    ovf_d      = conv_done ? ovf_pend_q : ovf_q;
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == CNTW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // upper_zero[i] is set when digit i and every digit above it are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam bit CAN_BLANK = (gi != 0);
    logic [3:0] nib;
    logic [6:0] body;
    assign nib = disp_q[4*gi +: 4];
    if (gi == DIGITS - 1) begin : g_top
      assign upper_zero[gi] = (nib == 4'd0);
    end else begin : g_low
      assign upper_zero[gi] = (nib == 4'd0) && upper_zero[gi+1];
    end
    assign body = ovf_q ? SEG_DASH
                : (CAN_BLANK && blank_lz && upper_zero[gi]) ? SEG_BLANK
                : seg_font(nib);
    assign seg_hi[gi] = {dp[gi], body};
  end

  assign onehot = DIGITS'(1) << idx_q;
  assign sel_d  = onehot ^ {DIGITS{INV}};
  assign seg_d  = seg_hi[idx_q] ^ {8{INV}};

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      idx_q      <= '0;
      scan_cnt_q <= '0;
      sel_q      <= {DIGITS{INV}};
      seg_q      <= {8{INV}};
    end else begin
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      idx_q      <= idx_d;
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign overflow = ovf_q;
  assign sel      = sel_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl (4 digits, 16-bit data, SCAN_DIV=4, active-low).
// Directed table vectors, hand-written handshake/reset sequences, then random values vs a model.
module tb_seg_display_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int WIDTH    = 16;

  typedef logic [3:0][7:0] codes_t;
  typedef struct {
    string       name;
    logic [15:0] data;
    bit          dec;
    bit          blank;
    logic [3:0]  dpv;
    bit          ovf;
    codes_t      exp;
  } vec_t;

  localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic        load = 1'b0;
  logic        dec_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp = '0;
  logic        busy, overflow;
  logic [3:0]  sel;
  logic [7:0]  seg;

  int n_cmp = 0;
  int n_err = 0;

  seg_display_ctrl #(.DIGITS(4), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .data(data), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .dp(dp), .busy(busy), .overflow(overflow), .sel(sel), .seg(seg)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: digits by division in the chosen base; blanked when the value is below base^i.
  function automatic codes_t model_codes(input int unsigned v, input bit dec, input bit blank,
                                         input logic [3:0] dpv);
    codes_t r;
    int unsigned base, p, d;
    bit ovf;
    base = dec ? 10 : 16;
    ovf  = dec ? (v >= 10000) : (v >= 65536);
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d = (v / p) % base;
      if (ovf) r[i] = 8'hBF;
      else if (blank && i > 0 && v < p) r[i] = 8'hFF;
      else r[i] = FONT[d];
      if (dpv[i]) r[i] = r[i] & 8'h7F;
      p = p * base;
    end
    return r;
  endfunction

  function automatic bit model_ovf(input int unsigned v, input bit dec);
    return dec ? (v >= 10000) : (v >= 65536);
  endfunction

  task automatic pulse_load(input logic [15:0] v, input bit dec);
    data = v; dec_mode = dec; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Two full scan rotations: one active sel, seg matches the digit shown, index steps by one.
  task automatic check_scan(input codes_t exp, input string name);
    int dig, prev;
    logic [3:0] seen, m;
    prev = -1;
    seen = '0;
    repeat (2 * 4 * SCAN_DIV) begin
      @(negedge clk);
      dig = -1;
      for (int i = 0; i < 4; i++) begin
        m = 4'b0001 << i;
        if (sel === ~m) dig = i;
      end
      if (dig < 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s sel_onehot: got %h expected one low bit", name, sel);
      end else begin
        check($sformatf("%s seg[%0d]", name, dig), seg, exp[dig]);
        seen[dig] = 1'b1;
        if (prev >= 0 && dig != prev)
          check($sformatf("%s scan_order", name), dig, (prev + 1) % 4);
        prev = dig;
      end
    end
    check($sformatf("%s digits_seen", name), seen, 4'hF);
  endtask

  task automatic run_case(input string name, input logic [15:0] v, input bit dec, input bit blank,
                          input logic [3:0] dpv, input bit exp_ovf, input codes_t exp);
    int n;
    blank_lz = blank;
    dp = dpv;
    pulse_load(v, dec);
    wait_idle(n);
    check({name, " busy_cycles"}, n, WIDTH + 1);
    check({name, " overflow"}, overflow, exp_ovf);
    $display("txn %s: data=%0d dec=%0b blank=%0b dp=%b busy_cycles=%0d ovf=%0b",
             name, v, dec, blank, dpv, n, overflow);
    check_scan(exp, name);
  endtask

  vec_t vecs [9];

  initial begin
    int n;
    codes_t zeros;
    logic [15:0] rv;
    bit rdec, rblank;
    logic [3:0] rdp;

    zeros = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
    vecs[0] = '{"hex_1A2F",  16'h1A2F, 1'b0, 1'b0, 4'b0000, 1'b0, {8'hF9, 8'h88, 8'hA4, 8'h8E}};
    vecs[1] = '{"dec_1234",  16'd1234, 1'b1, 1'b0, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[2] = '{"dec_9999",  16'd9999, 1'b1, 1'b0, 4'b0000, 1'b0, {8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[3] = '{"dec_10000", 16'd10000, 1'b1, 1'b0, 4'b0000, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[4] = '{"blank_7",   16'd7,    1'b1, 1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
    vecs[5] = '{"blank_0",   16'd0,    1'b1, 1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[6] = '{"blank_dp",  16'd7,    1'b1, 1'b1, 4'b0100, 1'b0, {8'hFF, 8'h7F, 8'hFF, 8'hF8}};
    vecs[7] = '{"hex_FFFF",  16'hFFFF, 1'b0, 1'b1, 4'b0000, 1'b0, {8'h8E, 8'h8E, 8'h8E, 8'h8E}};
    vecs[8] = '{"ovf_dp",    16'd65535, 1'b1, 1'b1, 4'b0001, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'h3F}};

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset sel", sel, 4'hF);
      check("reset seg", seg, 8'hFF);
      check("reset busy", busy, 1'b0);
      check("reset overflow", overflow, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_reset sel", sel, 4'hE);
    check("post_reset seg", seg, 8'hC0);
    $display("txn reset: sel=%h seg=%h busy=%0b", sel, seg, busy);
    check_scan(zeros, "reset_scan");

    foreach (vecs[i])
      run_case(vecs[i].name, vecs[i].data, vecs[i].dec, vecs[i].blank, vecs[i].dpv,
               vecs[i].ovf, vecs[i].exp);

    // A load while busy is dropped.
    blank_lz = 1'b0;
    dp = '0;
    pulse_load(16'd100, 1'b1);
    repeat (4) @(negedge clk);
    check("drop busy_before", busy, 1'b1);
    pulse_load(16'd200, 1'b1);
    wait_idle(n);
    check("drop busy_remaining", n, WIDTH - 4);
    $display("txn drop: first=100 second=200 (while busy) remaining_busy=%0d", n);
    check_scan(model_codes(100, 1'b1, 1'b0, 4'b0000), "drop_shows_100");
    run_case("after_drop_200", 16'd200, 1'b1, 1'b0, 4'b0000, 1'b0,
             model_codes(200, 1'b1, 1'b0, 4'b0000));

    // Reset mid-conversion of an overflowing value aborts with no commit.
    pulse_load(16'd10000, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst overflow", overflow, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("midrst no_commit", {busy, overflow}, 2'b00);
    end
    $display("txn midrst: busy=%0b overflow=%0b", busy, overflow);
    check_scan(zeros, "midrst_scan");

    // Load coincident with reset loses.
    rst = 1'b1;
    data = 16'd55;
    dec_mode = 1'b1;
    load = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    check("rst_load busy", busy, 1'b0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("rst_load idle", busy, 1'b0);
    end
    $display("txn rst_load: busy=%0b", busy);
    check_scan(zeros, "rst_load_scan");

    // Random values against the reference model.
    for (int t = 0; t < 30; t++) begin
      rv     = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 150))
                                           : 16'($urandom_range(0, 65535));
      rdec   = 1'($urandom_range(0, 1));
      rblank = 1'($urandom_range(0, 1));
      rdp    = 4'($urandom_range(0, 15));
      run_case($sformatf("rand%0d", t), rv, rdec, rblank, rdp, model_ovf(rv, rdec),
               model_codes(rv, rdec, rblank, rdp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
